// File: rtl/aes_pkg.sv
// Shared AES-128 key schedule types, constants and word-level helpers.
package aes_pkg;

    localparam int unsigned NR = 10;

    typedef enum logic {StIdle, StEmit} state_e;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] key128_t;

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Ripples the round temp word through w0..w3 to form the next round key.
    function automatic key128_t xor_chain(input key128_t k, input word_t t);
        word_t w0;
        word_t w1;
        word_t w2;
        word_t w3;
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_rcon.sv
// Round-constant XOR: folds RCON[round] into the top byte of the temp word.
module aes_rcon
    import aes_pkg::*;
(
    input  logic [3:0] i_round,
    input  word_t      i_word,
    output word_t      o_word
);

    logic [7:0] w_rc;

    always_comb begin
        w_rc = 8'h00;
        case (i_round)
            4'd0:    w_rc = 8'h01;
            4'd1:    w_rc = 8'h02;
            4'd2:    w_rc = 8'h04;
            4'd3:    w_rc = 8'h08;
            4'd4:    w_rc = 8'h10;
            4'd5:    w_rc = 8'h20;
            4'd6:    w_rc = 8'h40;
            4'd7:    w_rc = 8'h80;
            4'd8:    w_rc = 8'h1b;
            4'd9:    w_rc = 8'h36;
            default: w_rc = 8'h00;
        endcase
    end

    assign o_word = i_word ^ {w_rc, 24'h000000};

endmodule

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes128_key_expander.sv
// Sequential AES-128 key schedule: streams round keys 0..10 over valid/ready.
module aes128_key_expander
    import aes_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [127:0]   i_key_in,
    input  logic           i_abort,
    output logic           o_rk_valid,
    input  logic           i_rk_ready,
    output logic [127:0]   o_rk_data,
    output logic [3:0]     o_rk_index,
    output logic           o_busy,
    output logic           o_done
);

    localparam logic [3:0] LastIdx = 4'(NR);

    state_e  r_state;
    key128_t r_key;
    logic [3:0] r_idx;
    logic    r_valid;
    logic    r_busy;
    logic    r_done;

    word_t   w_rot;
    word_t   w_sub;
    word_t   w_temp;
    key128_t w_next;

    assign w_rot = rot_word(r_key[31:0]);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    aes_rcon u_rcon (
        .i_round (r_idx),
        .i_word  (w_sub),
        .o_word  (w_temp)
    );

    assign w_next = xor_chain(r_key, w_temp);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_key   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_state <= StIdle;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (i_start) begin
                            r_key   <= i_key_in;
                            r_idx   <= '0;
                            r_state <= StEmit;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                    StEmit: begin
                        // Indices past the last round are unreachable; bail out safely.
                        if (r_idx > LastIdx) begin
                            r_state <= StIdle;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                        end else if (i_rk_ready) begin
                            if (r_idx == LastIdx) begin
                                r_state <= StIdle;
                                r_valid <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_key <= w_next;
                                r_idx <= r_idx + 4'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_rk_valid = r_valid;
    assign o_rk_data  = r_key;
    assign o_rk_index = r_idx;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_aes128_key_expander.sv
// Self-checking bench: GF(2^8)-derived key schedule model plus directed scenarios.
module tb_aes128_key_expander;

    localparam logic [127:0] KeyA1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1Rk1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1Rk10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZeroRk1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] KeySeq  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         abort = 1'b0;
    logic         rk_ready = 1'b1;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [256];

    bit           m_active = 1'b0;
    bit           m_done = 1'b0;
    int           m_idx = 0;
    logic [127:0] m_key = '0;

    always #5 clk = ~clk;

    aes128_key_expander dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_key_in   (key_in),
        .i_abort    (abort),
        .o_rk_valid (rk_valid),
        .i_rk_ready (rk_ready),
        .o_rk_data  (rk_data),
        .o_rk_index (rk_index),
        .o_busy     (busy),
        .o_done     (done)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // Textbook key expansion from the cipher key, round by round.
    function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
        logic [31:0] w [4];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int r = 0; r < n; r++) begin
            t = {w[3][23:0], w[3][31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            t = t ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            w[0] = w[0] ^ t;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // Transaction-level model of what the stream must be doing.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_idx    <= 0;
        end else begin
            m_done <= 1'b0;
            if (abort) begin
                m_active <= 1'b0;
            end else if (!m_active) begin
                if (start) begin
                    m_active <= 1'b1;
                    m_key    <= key_in;
                    m_idx    <= 0;
                end
            end else if (rk_ready) begin
                if (m_idx == 10) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", 128'(rk_valid), 128'd0);
            chk("rst_busy", 128'(busy), 128'd0);
            chk("rst_done", 128'(done), 128'd0);
            chk("rst_data", rk_data, 128'd0);
            chk("rst_index", 128'(rk_index), 128'd0);
        end else begin
            chk("cyc_valid", 128'(rk_valid), 128'(m_active));
            chk("cyc_busy", 128'(busy), 128'(m_active));
            chk("cyc_done", 128'(done), 128'(m_done));
            if (m_active) begin
                chk("cyc_index", 128'(rk_index), 128'(m_idx));
                chk("cyc_data", rk_data, round_key(m_key, m_idx));
            end
        end
    end

    task automatic pulse_start(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk(name, 128'(done), 128'd1);
    endtask

    // Streams with ready held high; expects 11 back-to-back keys then done.
    task automatic run_stream(input logic [127:0] rk1, input logic [127:0] rk10,
                              input bit check10, input string name);
        int n;
        n = 0;
        while (rk_valid && n < 20) begin
            if (rk_index == 4'd1) chk({name, "_rk1"}, rk_data, rk1);
            if (check10 && rk_index == 4'd10) chk({name, "_rk10"}, rk_data, rk10);
            n++;
            @(negedge clk);
        end
        chk({name, "_len"}, 128'(n), 128'd11);
        chk({name, "_done"}, 128'(done), 128'd1);
    endtask

    initial begin
        bit pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int acc;
        logic [127:0] prev_data;
        logic [3:0]   prev_idx;
        bit           held;

        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[a] = s;
        end

        chk("model_sbox_00", 128'(sb[8'h00]), 128'h63);
        chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);
        chk("model_a1_rk1", round_key(KeyA1, 1), A1Rk1);
        chk("model_a1_rk10", round_key(KeyA1, 10), A1Rk10);
        chk("model_zero_rk1", round_key(128'd0, 1), ZeroRk1);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 128'(busy), 128'd0);

        // FIPS-197 A.1 key, then a start on the done cycle with the all-zero key.
        pulse_start(KeyA1);
        chk("a1_first_key", rk_data, KeyA1);
        run_stream(A1Rk1, A1Rk10, 1'b1, "a1");
        pulse_start(128'd0);
        chk("zero_after_done_idx", 128'(rk_index), 128'd0);
        run_stream(ZeroRk1, 128'd0, 1'b0, "zero");
        @(negedge clk);

        // Backpressure with a repeating ready pattern.
        pulse_start(KeyA1);
        acc  = 0;
        held = 1'b0;
        prev_data = '0;
        prev_idx  = '0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (done) break;
            if (held) begin
                chk("bp_hold_data", rk_data, prev_data);
                chk("bp_hold_idx", 128'(rk_index), 128'(prev_idx));
            end
            rk_ready = pat[cyc % 8];
            if (rk_valid && rk_ready) begin
                chk("bp_order", 128'(rk_index), 128'(acc));
                acc++;
            end
            held = rk_valid && !rk_ready;
            prev_data = rk_data;
            prev_idx  = rk_index;
            @(negedge clk);
        end
        chk("bp_count", 128'(acc), 128'd11);
        chk("bp_done", 128'(done), 128'd1);
        rk_ready = 1'b1;
        @(negedge clk);

        // Start while busy with another key must be ignored.
        pulse_start(KeySeq);
        repeat (3) @(negedge clk);
        pulse_start(~KeySeq);
        wait_done(20, "busy_start_done");
        @(negedge clk);

        // Abort at round 5.
        pulse_start(KeyA1);
        for (int i = 0; i < 20; i++) begin
            if (rk_valid && rk_index == 4'd5) break;
            @(negedge clk);
        end
        chk("abort_reach5", 128'(rk_index), 128'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", 128'(rk_valid), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        repeat (3) begin
            chk("abort_no_done", 128'(done), 128'd0);
            @(negedge clk);
        end
        pulse_start(KeySeq);
        chk("post_abort_rk0", rk_data, KeySeq);
        wait_done(20, "post_abort_done");
        @(negedge clk);

        // Asynchronous reset in the middle of a stream.
        pulse_start(KeyA1);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 128'(rk_valid), 128'd0);
        chk("async_rst_busy", 128'(busy), 128'd0);
        chk("async_rst_data", rk_data, 128'd0);
        chk("async_rst_idx", 128'(rk_index), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 128'(busy), 128'd0);
        pulse_start(KeyA1);
        chk("post_rst_rk0", rk_data, KeyA1);
        wait_done(20, "post_rst_done");
        @(negedge clk);

        // Start and abort together in idle: nothing is captured.
        key_in = KeySeq;
        start  = 1'b1;
        abort  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        abort  = 1'b0;
        chk("start_abort_valid", 128'(rk_valid), 128'd0);
        chk("start_abort_busy", 128'(busy), 128'd0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes128_key_expander.md
Name: aes128_key_expander

Overview:
- Sequential AES-128 key schedule engine; takes the 128-bit cipher key and emits round keys 0..10, one per valid/ready handshake.
- Builds the temp word for each round as SubWord(RotWord(w3)) and feeds it to the existing rcon block.
- Consumes the rcon output to form the next round key's four words.
- Sits between the key-load interface and the cipher round datapath, or a round-key store.

Parameters:
- None. AES-128 only; NR = 10 is a package constant.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin expansion of key_in; sampled in IDLE only
- key_in  input  128  cipher key, w0 = bits [127:96]; captured on accepted start
- abort  input  1  synchronous cancel; returns to IDLE next cycle
- rk_valid  output  1  rk_data / rk_index valid
- rk_ready  input  1  downstream accepts the current round key
- rk_data  output  128  current round key, w0 in [127:96]
- rk_index  output  4  round number of rk_data, 0..10
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse after round key 10 is accepted

Behaviour:
- Reset (async, rst_n = 0): state IDLE; key_reg = 0; idx = 0; rk_valid = 0; done = 0; busy = 0. All outputs read 0 during reset.
- Reset released mid-expansion: the block restarts from IDLE; no partial resume.
- State IDLE:
  - start = 1 → key_reg <= key_in, idx <= 0, go to EMIT.
  - rk_valid = 1 in the cycle after start. Start-to-first-key latency is 1 cycle.
- State EMIT:
  - rk_valid = 1; rk_data = key_reg; rk_index = idx.
  - Outputs are held stable while rk_ready = 0 (AXI-style; valid never drops without a handshake).
- Handshake in EMIT (rk_valid & rk_ready):
  - If idx < 10: key_reg <= next_key, idx <= idx + 1, stay in EMIT. rk_valid stays 1, so with rk_ready held high all 11 keys stream on 11 consecutive cycles.
  - If idx == 10: go to IDLE, done = 1 for exactly one cycle, rk_valid = 0.
- next_key (combinational from key_reg):
  - temp = SubWord(RotWord(w3)). RotWord is a left rotate by 8 bits, {w3[23:0], w3[31:24]}. SubWord applies the AES S-box to each byte.
  - t = rcon(round = idx, in = temp), i.e. the RCON[idx] XOR. idx is 0..9 whenever it is used.
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
- start while busy: ignored. key_in is not recaptured.
- abort (any state): next cycle state = IDLE, rk_valid = 0, done = 0. abort has priority over a simultaneous handshake or start.
- start together with abort in IDLE: abort wins; nothing is captured.
- done and start in the same cycle: done is a registered output and the FSM is already back in IDLE, so start is accepted and the new key appears on the next cycle.
- idx never exceeds 10. Values 11..15 are unreachable; if reached, the FSM forces IDLE.
- Critical path per key: one S-box, the rcon XOR and a chain of four XORs. No pipelining.

Decomposition:
- aes_pkg:
  - NR = 10.
  - state enum {IDLE, EMIT}.
  - Word typedef word_t (32 bits), key typedef key128_t (128 bits).
  - Functions rot_word and xor_chain.
- Sub-modules:
  - Four instances of aes_sbox (combinational, 8-bit in / 8-bit out). This is the one natural sub-module and is shared with the cipher SubBytes stage.
  - One instance of the existing rcon block for the round-constant XOR.
- Top-level RTL holds the FSM, key_reg, idx and the handshake logic.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1 → 11 consecutive rk_valid cycles with the following, then a done pulse on the next cycle:
  - rk_index 0: key unchanged
  - rk_index 1: a0fafe1788542cb123a339392a6c7605
  - rk_index 10: d014f9a8c9ee2589e13f0cc8b6630ca6
- All-zero key → round 1 = 62636363626363636263636362636363. Round 10 matches the software model.
- Backpressure: rk_ready toggles randomly (pattern 1,0,0,1,...) → rk_data/rk_index stay stable while rk_ready = 0; the same 11 keys appear in order; no key is skipped or duplicated.
- start pulsed while busy with a different key_in → ignored; expansion of the original key completes with unchanged values.
- abort asserted at rk_index 5 → next cycle rk_valid = 0 and busy = 0, with no done pulse; a new start then produces round 0 correctly.
- rst_n dropped asynchronously mid-EMIT → outputs go to 0 immediately; after release the block is in IDLE with busy = 0, and a new start works.
